// File: rtl/shake_host_if.sv
// Host-side initiator for the SHAKE core stream: sends the length header, forwards
// message words, then collects squeezed words through a 1-deep skid with tail masking.
module shake_host_if #(
  parameter int W     = 32,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] in_len_bits,
  input  logic [LEN_W-1:0] out_len_bits,
  input  logic             abort,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [W-1:0]     msg_data,
  output logic             core_din_valid,
  input  logic             core_din_ready,
  output logic [W-1:0]     core_din,
  input  logic             core_dout_valid,
  output logic             core_dout_ready,
  input  logic [W-1:0]     core_dout,
  output logic             core_force_done,
  input  logic             core_force_done_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_OUT = 3'd1,
    HDR_IN  = 3'd2,
    MSG     = 3'd3,
    SQZ     = 3'd4,
    ABORT   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [LEN_W:0] CNT_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W+1)'(1);

  state_t           state_r;
  state_t           state_s;
  logic [LEN_W-1:0] in_len_r;
  logic [LEN_W-1:0] out_len_r;
  logic [LEN_W:0]   msg_cnt_r;
  logic [LEN_W:0]   out_cnt_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [W-1:0]     out_data_r;

  logic             start_ok_s;
  logic             active_s;
  logic             msg_xfer_s;
  logic             dout_xfer_s;
  logic             out_xfer_s;
  logic [LEN_W-1:0] tail_bits_s;
  logic [W-1:0]     keep_mask_s;
  logic             core_din_valid_s;
  logic [W-1:0]     core_din_s;
  logic             msg_ready_s;
  logic             core_dout_ready_s;
  logic             core_force_done_s;

  // One extra bit keeps the round-up from wrapping at the maximum length.
  function automatic logic [LEN_W:0] ceil_words(input logic [LEN_W-1:0] bits);
    logic [LEN_W:0] sum_v;
    sum_v = {1'b0, bits} + (LEN_W+1)'(W - 1);
    return sum_v / (LEN_W+1)'(W);
  endfunction

  assign start_ok_s  = start && (out_len_bits != {LEN_W{1'b0}});
  assign active_s    = (state_r == HDR_OUT) || (state_r == HDR_IN) ||
                       (state_r == MSG) || (state_r == SQZ);
  assign tail_bits_s = out_len_r % LEN_W'(W);
  assign keep_mask_s = (tail_bits_s == {LEN_W{1'b0}}) ? {W{1'b1}} : ~({W{1'b1}} >> tail_bits_s);
  assign msg_xfer_s  = (state_r == MSG) && core_din_valid_s && core_din_ready;
  assign dout_xfer_s = core_dout_ready_s && core_dout_valid;
  assign out_xfer_s  = out_valid_r && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over any handshake in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = HDR_OUT;
        else            state_s = IDLE;
      end
      HDR_OUT: begin
        if (abort)               state_s = ABORT;
        else if (core_din_ready) state_s = HDR_IN;
        else                     state_s = HDR_OUT;
      end
      HDR_IN: begin
        if (abort)               state_s = ABORT;
        else if (core_din_ready) state_s = (msg_cnt_r == CNT_ZERO) ? SQZ : MSG;
        else                     state_s = HDR_IN;
      end
      MSG: begin
        if (abort)                                   state_s = ABORT;
        else if (msg_xfer_s && msg_cnt_r == CNT_ONE) state_s = SQZ;
        else                                         state_s = MSG;
      end
      SQZ: begin
        if (abort)                         state_s = ABORT;
        else if (out_xfer_s && out_last_r) state_s = DONE;
        else                               state_s = SQZ;
      end
      ABORT: begin
        if (core_force_done_ack) state_s = DONE;
        else                     state_s = ABORT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Core-side and upstream handshake outputs decoded from the state.
  always_comb begin
    core_din_valid_s  = 1'b0;
    core_din_s        = {W{1'b0}};
    msg_ready_s       = 1'b0;
    core_dout_ready_s = 1'b0;
    core_force_done_s = 1'b0;
    case (state_r)
      HDR_OUT: begin
        core_din_valid_s = !abort;
        core_din_s       = W'(out_len_r);
      end
      HDR_IN: begin
        core_din_valid_s = !abort;
        core_din_s       = W'(in_len_r);
      end
      MSG: begin
        core_din_valid_s = msg_valid && !abort;
        core_din_s       = msg_data;
        msg_ready_s      = core_din_ready && !abort;
      end
      SQZ: begin
        core_dout_ready_s = !abort && (out_cnt_r != CNT_ZERO) && (!out_valid_r || out_ready);
      end
      ABORT: begin
        core_force_done_s = 1'b1;
      end
      default: begin
        core_din_valid_s = 1'b0;
      end
    endcase
  end

  // Request latch, word counters and output skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_len_r    <= {LEN_W{1'b0}};
      out_len_r   <= {LEN_W{1'b0}};
      msg_cnt_r   <= CNT_ZERO;
      out_cnt_r   <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {W{1'b0}};
    end else begin
      if (state_r == IDLE && start_ok_s) begin
        in_len_r  <= in_len_bits;
        out_len_r <= out_len_bits;
        msg_cnt_r <= ceil_words(in_len_bits);
        out_cnt_r <= ceil_words(out_len_bits);
      end
      if (msg_xfer_s) begin
        msg_cnt_r <= msg_cnt_r - CNT_ONE;
      end
      if (active_s && abort) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        out_data_r  <= {W{1'b0}};
      end else if (dout_xfer_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= (out_cnt_r == CNT_ONE);
        out_data_r  <= core_dout & ((out_cnt_r == CNT_ONE) ? keep_mask_s : {W{1'b1}});
        out_cnt_r   <= out_cnt_r - CNT_ONE;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign core_din_valid  = core_din_valid_s;
  assign core_din        = core_din_s;
  assign msg_ready       = msg_ready_s;
  assign core_dout_ready = core_dout_ready_s;
  assign core_force_done = core_force_done_s;
  assign out_valid       = out_valid_r;
  assign out_data        = out_data_r;
  assign out_last        = out_last_r;
  assign busy            = (state_r != IDLE);
  assign done            = (state_r == DONE);

endmodule

// File: tb/tb_shake_host_if.sv
// Directed bench for shake_host_if: table of requests run against a small core model,
// plus hand-written abort and reset sequences.
module tb_shake_host_if;
  localparam int W     = 32;
  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] in_len_bits;
  logic [LEN_W-1:0] out_len_bits;
  logic             abort;
  logic             msg_valid;
  logic             msg_ready;
  logic [W-1:0]     msg_data;
  logic             core_din_valid;
  logic             core_din_ready;
  logic [W-1:0]     core_din;
  logic             core_dout_valid;
  logic             core_dout_ready;
  logic [W-1:0]     core_dout;
  logic             core_force_done;
  logic             core_force_done_ack;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  shake_host_if #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_len_bits(in_len_bits),
    .out_len_bits(out_len_bits), .abort(abort), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .msg_data(msg_data), .core_din_valid(core_din_valid),
    .core_din_ready(core_din_ready), .core_din(core_din),
    .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
    .core_dout(core_dout), .core_force_done(core_force_done),
    .core_force_done_ack(core_force_done_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] in_len;
    logic [31:0] out_len;
    logic [31:0] dout_base;
    logic [31:0] dout_step;
    bit          stall;
    int          exp_msg;
    int          exp_out;
    logic [31:0] last_mask;
  } vec_t;

  vec_t tbl [5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic rbit(input bit stall);
    return stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; in_len_bits = '0; out_len_bits = '0; abort = 1'b0;
    msg_valid = 1'b0; msg_data = '0; core_din_ready = 1'b0;
    core_dout_valid = 1'b0; core_dout = '0; core_force_done_ack = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] din_log [$];
    logic [31:0] exp_w;
    int msg_idx = 0, core_idx = 0, out_idx = 0, done_cnt = 0, extra = 0, cyc = 0;
    bit saw_mr = 1'b0;
    @(negedge clk);
    start = 1'b1; in_len_bits = v.in_len; out_len_bits = v.out_len;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d busy_after_start", idx), 64'(busy), 64'd1);
    while (done_cnt == 0 && cyc < 3000) begin
      msg_valid       = rbit(v.stall);
      msg_data        = 32'h5A00_0000 + 32'(msg_idx);
      core_din_ready  = rbit(v.stall);
      core_dout_valid = rbit(v.stall);
      core_dout       = v.dout_base + 32'(core_idx) * v.dout_step;
      out_ready       = rbit(v.stall);
      #1;
      if (core_din_valid && core_din_ready) din_log.push_back(core_din);
      if (msg_ready) saw_mr = 1'b1;
      if (msg_valid && msg_ready) msg_idx++;
      if (core_dout_ready && core_idx >= v.exp_out) extra++;
      if (core_dout_valid && core_dout_ready) core_idx++;
      if (out_valid && out_ready) begin
        exp_w = (v.dout_base + 32'(out_idx) * v.dout_step) &
                ((out_idx == v.exp_out - 1) ? v.last_mask : 32'hFFFF_FFFF);
        check($sformatf("v%0d out_data[%0d]", idx, out_idx), 64'(out_data), 64'(exp_w));
        check($sformatf("v%0d out_last[%0d]", idx, out_idx), 64'(out_last),
              64'(out_idx == v.exp_out - 1));
        out_idx++;
      end
      if (done) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    check($sformatf("v%0d done_seen", idx), 64'(done_cnt), 64'd1);
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d busy_dropped", idx), 64'(busy), 64'd0);
    check($sformatf("v%0d din_count", idx), 64'(din_log.size()), 64'(2 + v.exp_msg));
    if (din_log.size() >= 2) begin
      check($sformatf("v%0d hdr_out_len", idx), 64'(din_log[0]), 64'(v.out_len));
      check($sformatf("v%0d hdr_in_len", idx), 64'(din_log[1]), 64'(v.in_len));
    end
    for (int i = 2; i < din_log.size(); i++)
      check($sformatf("v%0d msg_word[%0d]", idx, i - 2), 64'(din_log[i]),
            64'(32'h5A00_0000 + 32'(i - 2)));
    check($sformatf("v%0d msg_count", idx), 64'(msg_idx), 64'(v.exp_msg));
    check($sformatf("v%0d core_words", idx), 64'(core_idx), 64'(v.exp_out));
    check($sformatf("v%0d out_words", idx), 64'(out_idx), 64'(v.exp_out));
    check($sformatf("v%0d no_extra_req", idx), 64'(extra), 64'd0);
    if (v.exp_msg == 0) check($sformatf("v%0d msg_ready_never", idx), 64'(saw_mr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_msg;
    int guard;
    tbl[0] = '{32'd64,  32'd256, 32'h1000_0000, 32'h0101_0101, 1'b0, 2,  8, 32'hFFFF_FFFF};
    tbl[1] = '{32'd0,   32'd32,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0,  1, 32'hFFFF_FFFF};
    tbl[2] = '{32'd8,   32'd40,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1,  2, 32'hFF00_0000};
    tbl[3] = '{32'd33,  32'd512, 32'h8765_4321, 32'h0000_1111, 1'b1, 2, 16, 32'hFFFF_FFFF};
    tbl[4] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4,  4, 32'hF000_0000};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst core_din_valid", 64'(core_din_valid), 64'd0);
    check("rst force_done", 64'(core_force_done), 64'd0);
    rst = 1'b0;

    // zero output length is ignored
    @(negedge clk);
    start = 1'b1; in_len_bits = 32'd64; out_len_bits = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_out_len ignored", 64'(busy), 64'd0);

    for (int k = 0; k < 5; k++) run_vec(k, tbl[k]);

    // abort during MSG after 3 of 5 words; start with simultaneous abort is taken
    @(negedge clk);
    start = 1'b1; abort = 1'b1; in_len_bits = 32'd160; out_len_bits = 32'd64;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_over_abort busy", 64'(busy), 64'd1);
    msg_valid = 1'b1; core_din_ready = 1'b1; msg_data = 32'h0BAD_0000;
    n_msg = 0; guard = 0;
    while (n_msg < 3 && guard < 20) begin
      #1;
      if (msg_valid && msg_ready) n_msg++;
      @(negedge clk);
      guard++;
    end
    check("abort msg_before", 64'(n_msg), 64'd3);
    abort = 1'b1;
    #1;
    check("abort msg_ready_gated", 64'(msg_ready), 64'd0);
    check("abort din_valid_gated", 64'(core_din_valid), 64'd0);
    @(negedge clk);
    check("abort force_done c1", 64'(core_force_done), 64'd1);
    check("abort msg_ready c1", 64'(msg_ready), 64'd0);
    check("abort busy c1", 64'(busy), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    check("abort force_done c2", 64'(core_force_done), 64'd1);
    check("abort out_valid c2", 64'(out_valid), 64'd0);
    core_force_done_ack = 1'b1;
    @(negedge clk);
    core_force_done_ack = 1'b0;
    check("abort done pulse", 64'(done), 64'd1);
    check("abort force_done off", 64'(core_force_done), 64'd0);
    @(negedge clk);
    check("abort done low", 64'(done), 64'd0);
    check("abort busy dropped", 64'(busy), 64'd0);
    idle_inputs();

    // reset in the middle of SQZ
    @(negedge clk);
    start = 1'b1; in_len_bits = 32'd0; out_len_bits = 32'd64;
    @(negedge clk);
    start = 1'b0; core_din_ready = 1'b1; core_dout_valid = 1'b1;
    core_dout = 32'h1234_5678; out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("sqz out_valid", 64'(out_valid), 64'd1);
    check("sqz out_data", 64'(out_data), 64'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_data", 64'(out_data), 64'd0);
    check("midrst out_last", 64'(out_last), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst dout_ready", 64'(core_dout_ready), 64'd0);
    start = 1'b1; in_len_bits = 32'd64; out_len_bits = 32'd0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("midrst idle busy c%0d", c), 64'(busy), 64'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
